// File: rtl/sec_tick_ctrl_pkg.sv
// rtl/sec_tick_ctrl_pkg.sv - mode encodings, default rates and counter width helper
package sec_tick_ctrl_pkg;

  typedef enum logic {
    MODE_RUN = 1'b0,
    MODE_SET = 1'b1
  } mode_t;

`ifdef SIM
  localparam int DEF_CLK_HZ       = 10;
  localparam int DEF_DEBOUNCE_CYC = 4;
  localparam int DEF_REPEAT_DLY   = 20;
  localparam int DEF_REPEAT_PER   = 5;
`else
  localparam int DEF_CLK_HZ       = 50_000_000;
  localparam int DEF_DEBOUNCE_CYC = 1_000_000;
  localparam int DEF_REPEAT_DLY   = 25_000_000;
  localparam int DEF_REPEAT_PER   = 5_000_000;
`endif

  // Width of a counter that spans 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sec_tick_ctrl_debounce.sv
// rtl/sec_tick_ctrl_debounce.sv - button synchroniser, stability counter and rise pulse
module btn_debounce
  import sec_tick_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int            CW      = cnt_w(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      // rise is registered alongside level so both change on the same edge
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt   <= '0;
        level <= sync2;
        rise  <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sec_tick_ctrl.sv
// rtl/sec_tick_ctrl.sv - 1 Hz prescaler, RUN/SET mode FSM and incr/dcr auto-repeat
module sec_tick_ctrl
  import sec_tick_ctrl_pkg::*;
#(
  parameter int CLK_HZ       = DEF_CLK_HZ,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DLY   = DEF_REPEAT_DLY,
  parameter int REPEAT_PER   = DEF_REPEAT_PER
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_mode,
  input  logic btn_up,
  input  logic btn_dn,
  output logic sec_en,
  output logic incr,
  output logic dcr,
  output logic set_mode
);

  localparam int            PW       = cnt_w(CLK_HZ);
  localparam int            TW       = cnt_w((REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER);
  localparam logic [PW-1:0] PCNT_MAX = PW'(CLK_HZ - 1);
  localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DLY - 1);
  localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PER - 1);

  logic mode_level, mode_rise;
  logic up_level, up_rise;
  logic dn_level, dn_rise;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mode (
    .clk(clk), .rst(rst), .raw(btn_mode), .level(mode_level), .rise(mode_rise)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
    .clk(clk), .rst(rst), .raw(btn_up), .level(up_level), .rise(up_rise)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dn (
    .clk(clk), .rst(rst), .raw(btn_dn), .level(dn_level), .rise(dn_rise)
  );

  mode_t         mode;
  logic [PW-1:0] pcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode   <= MODE_RUN;
      pcnt   <= '0;
      sec_en <= 1'b0;
    end else begin
      if (mode_rise && mode_level) begin
        mode <= (mode == MODE_RUN) ? MODE_SET : MODE_RUN;
      end
      // Holding the count at 0 in SET makes the first tick after SET->RUN land a full period later
      if (mode == MODE_SET) begin
        pcnt   <= '0;
        sec_en <= 1'b0;
      end else begin
        sec_en <= (pcnt == PCNT_MAX);
        pcnt   <= (pcnt == PCNT_MAX) ? '0 : pcnt + PW'(1);
      end
    end
  end

  assign set_mode = (mode == MODE_SET);

  // Channel 0 drives incr from up, channel 1 drives dcr from down.
  logic [1:0] key_lvl, key_rise, key_other, key_pulse;

  assign key_lvl   = {dn_level, up_level};
  assign key_rise  = {dn_rise, up_rise};
  assign key_other = {up_level, dn_level};

  for (genvar g = 0; g < 2; g++) begin : g_key
    logic          act;
    logic          rpt;
    logic          pulse;
    logic [TW-1:0] tmr;

    always_ff @(posedge clk) begin
      if (rst) begin
        act   <= 1'b0;
        rpt   <= 1'b0;
        pulse <= 1'b0;
        tmr   <= '0;
      end else begin
        pulse <= 1'b0;
        // Only a fresh rising edge can re-arm a channel once it has been cancelled
        if (mode != MODE_SET || !key_lvl[g] || key_other[g]) begin
          act <= 1'b0;
          rpt <= 1'b0;
          tmr <= '0;
        end else if (key_rise[g]) begin
          pulse <= 1'b1;
          act   <= 1'b1;
          rpt   <= 1'b0;
          tmr   <= '0;
        end else if (act) begin
          if (tmr == (rpt ? PER_LAST : DLY_LAST)) begin
            pulse <= 1'b1;
            rpt   <= 1'b1;
            tmr   <= '0;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
      end
    end

    assign key_pulse[g] = pulse;
  end

  assign incr = key_pulse[0];
  assign dcr  = key_pulse[1];

endmodule

// File: tb/tb_sec_tick_ctrl.sv
// tb/tb_sec_tick_ctrl.sv - scoreboard bench for sec_tick_ctrl
module tb_sec_tick_ctrl;

  localparam int CLK_HZ = 10;
  localparam int DEB    = 4;
  localparam int RDLY   = 20;
  localparam int RPER   = 5;
  localparam int K_SEC  = 1;
  localparam int K_INC  = 2;
  localparam int K_DCR  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_mode = 1'b0;
  logic btn_up = 1'b0;
  logic btn_dn = 1'b0;
  logic sec_en, incr, dcr, set_mode;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int exp_q[$];
  bit chk_sec = 1'b1;

  sec_tick_ctrl #(
    .CLK_HZ(CLK_HZ), .DEBOUNCE_CYC(DEB), .REPEAT_DLY(RDLY), .REPEAT_PER(RPER)
  ) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_up(btn_up), .btn_dn(btn_dn),
    .sec_en(sec_en), .incr(incr), .dcr(dcr), .set_mode(set_mode)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Events are encoded as cycle*4+kind so a sorted queue is in time order.
  task automatic expect_ev(input int k, input int c);
    exp_q.push_back(c * 4 + k);
    exp_q.sort();
  endtask

  task automatic see(input int k);
    int ev;
    ev = cyc * 4 + k;
    if (exp_q.size() == 0) begin
      chk("unexpected_pulse", ev, -1);
    end else begin
      chk("pulse", ev, exp_q[0]);
      void'(exp_q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (incr === 1'b1) see(K_INC);
      if (dcr === 1'b1) see(K_DCR);
      if (sec_en === 1'b1 && chk_sec) see(K_SEC);
    end
  end

  task automatic run_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic enter_set();
    int p;
    p = cyc;
    btn_mode = 1'b1;
    run_to(p + 8);
    chk("enter_set_mode", set_mode, 1);
    chk_sec = 1'b1;
    run_to(p + 10);
    btn_mode = 1'b0;
    run_to(p + 20);
  endtask

  task automatic leave_set();
    int p;
    chk_sec = 1'b0;
    p = cyc;
    btn_mode = 1'b1;
    run_to(p + 8);
    chk("leave_set_mode", set_mode, 0);
    run_to(p + 10);
    btn_mode = 1'b0;
    run_to(p + 20);
  endtask

  initial begin
    int r, p;

    // reset state
    rst = 1'b1;
    run_to(3);
    chk("rst_sec_en", sec_en, 0);
    chk("rst_incr", incr, 0);
    chk("rst_dcr", dcr, 0);
    chk("rst_set_mode", set_mode, 0);

    // 1: idle RUN, ticks every CLK_HZ cycles
    rst = 1'b0;
    r = cyc;
    expect_ev(K_SEC, r + 10);
    expect_ev(K_SEC, r + 20);
    expect_ev(K_SEC, r + 30);
    run_to(r + 35);
    chk("t1_queue", exp_q.size(), 0);
    chk("t1_set_mode", set_mode, 0);
    chk_sec = 1'b0;

    // 2: glitch ignored, stable press enters SET, second press leaves it
    btn_mode = 1'b1;
    run_to(r + 37);
    btn_mode = 1'b0;
    run_to(r + 42);
    p = cyc;
    btn_mode = 1'b1;
    run_to(p + 6);
    chk("t2_before_set", set_mode, 0);
    run_to(p + 7);
    chk("t2_set_rise", set_mode, 1);
    run_to(p + 8);
    chk_sec = 1'b1;
    run_to(p + 10);
    btn_mode = 1'b0;
    run_to(p + 30);
    chk("t2_still_set", set_mode, 1);
    p = cyc;
    btn_mode = 1'b1;
    expect_ev(K_SEC, p + 17);
    expect_ev(K_SEC, p + 27);
    run_to(p + 6);
    chk("t2_before_run", set_mode, 1);
    run_to(p + 7);
    chk("t2_run_fall", set_mode, 0);
    run_to(p + 10);
    btn_mode = 1'b0;
    run_to(p + 30);
    chk("t2_queue", exp_q.size(), 0);
    chk_sec = 1'b0;

    // 3: hold up in SET, first pulse then delayed then periodic repeat
    enter_set();
    p = cyc;
    btn_up = 1'b1;
    expect_ev(K_INC, p + 7);
    expect_ev(K_INC, p + 27);
    for (int t = p + 32; t <= p + 62; t += 5) expect_ev(K_INC, t);
    run_to(p + 60);
    btn_up = 1'b0;
    run_to(p + 75);
    chk("t3_queue", exp_q.size(), 0);

    // 4: up pressed while down held blocks both; down needs a re-press
    p = cyc;
    btn_dn = 1'b1;
    expect_ev(K_DCR, p + 7);
    run_to(p + 10);
    btn_up = 1'b1;
    run_to(p + 30);
    btn_up = 1'b0;
    run_to(p + 60);
    chk("t4_hold_queue", exp_q.size(), 0);
    btn_dn = 1'b0;
    run_to(p + 80);
    btn_dn = 1'b1;
    expect_ev(K_DCR, p + 87);
    run_to(p + 85);
    btn_dn = 1'b0;
    run_to(p + 100);
    chk("t4_queue", exp_q.size(), 0);

    // 5: up ignored in RUN and across RUN->SET until re-pressed
    leave_set();
    p = cyc;
    btn_up = 1'b1;
    run_to(p + 30);
    enter_set();
    run_to(p + 55);
    btn_up = 1'b0;
    run_to(p + 80);
    chk("t5_no_incr", exp_q.size(), 0);
    p = cyc;
    btn_up = 1'b1;
    expect_ev(K_INC, p + 7);
    run_to(p + 5);
    btn_up = 1'b0;
    run_to(p + 20);
    chk("t5_queue", exp_q.size(), 0);

    // 6: reset in the middle of an auto-repeat
    p = cyc;
    btn_up = 1'b1;
    expect_ev(K_INC, p + 7);
    expect_ev(K_INC, p + 27);
    expect_ev(K_INC, p + 32);
    run_to(p + 34);
    rst = 1'b1;
    run_to(p + 35);
    rst = 1'b0;
    chk("t6_incr", incr, 0);
    chk("t6_dcr", dcr, 0);
    chk("t6_sec_en", sec_en, 0);
    chk("t6_set_mode", set_mode, 0);
    expect_ev(K_SEC, p + 45);
    expect_ev(K_SEC, p + 55);
    run_to(p + 60);
    btn_up = 1'b0;
    run_to(p + 62);
    chk("t6_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
